lpm_constant_sequencer: RTL and testbench

- Programmable constant source that holds a small table of lpm_width-bit constants.
- Plays the table out in address order over a valid/ready stream; single pass, or looped until stopped.
- Sits beside the LPM constant/arithmetic models as the block that configures and sequences constant operands into downstream datapaths (adders, multipliers, compare units).
- The host writes the table, then pulses start.

---
 rtl/lpm_constant_sequencer_pkg.sv | 16 +
 rtl/lpm_constant_sequencer_if.sv | 23 ++
 rtl/lpm_constseq_regfile.sv | 42 ++++
 rtl/lpm_constant_sequencer.sv | 160 ++++++++++++++++
 tb/tb_lpm_constant_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpm_constant_sequencer_pkg.sv
// Shared types for lpm_constant_sequencer: FSM encoding and pass counter width.
// Imported by the top level and the table register file.
package lpm_constant_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int PASS_W = 8;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lpm_constant_sequencer_if.sv
// Valid/ready stream carrying table constants from the sequencer
// to a downstream datapath.
interface lpm_constant_sequencer_if #(
  parameter int lpm_width = 8
);

  logic [lpm_width-1:0] result;
  logic                 result_valid;
  logic                 result_ready;

  modport master (
    output result,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    output result_ready
  );

endinterface

// File: rtl/lpm_constseq_regfile.sv
// Constant table: depth x width registers, async clear to the reset
// constant, one write port and one combinational read port.
module lpm_constseq_regfile
  import lpm_constant_sequencer_pkg::*;
#(
  parameter int             W     = 8,
  parameter int             DEPTH = 4,
  parameter int             AW    = 2,
  parameter logic [W-1:0]   CVAL  = '0
) (
  input  logic          clock,
  input  logic          aclr_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  localparam int IW = addr_bits(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;

  // Callers keep both addresses below DEPTH, so truncation is safe.
  assign widx = IW'(waddr_i);
  assign ridx = IW'(raddr_i);

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= CVAL;
      end
    end else if (we_i) begin
      mem_q[widx] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx];

endmodule

// File: rtl/lpm_constant_sequencer.sv
// Programmable constant table played out over a valid/ready stream.
// Define LPM_CONSTSEQ_REPEAT_EN to add a repeat_count pass counter.
module lpm_constant_sequencer
  import lpm_constant_sequencer_pkg::*;
#(
  parameter string                lpm_type    = "lpm_constant_sequencer",
  parameter int                   lpm_width   = 8,
  parameter int                   lpm_depth   = 4,
  parameter int                   lpm_widthad = 2,
  parameter logic [lpm_width-1:0] lpm_cvalue  = '0
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   wren,
  input  logic [lpm_widthad-1:0] wraddress,
  input  logic [lpm_width-1:0]   data,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop,
  input  logic [lpm_widthad-1:0] last_addr,
`ifdef LPM_CONSTSEQ_REPEAT_EN
  input  logic [PASS_W-1:0]      repeat_count,
`endif
  lpm_constant_sequencer_if.master st,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_err
);

  localparam int AW = lpm_widthad;
  localparam logic [AW:0]   DEPTH_X  = (AW+1)'(lpm_depth);
  localparam logic [AW-1:0] LAST_MAX = AW'(lpm_depth - 1);

  if (lpm_type != "lpm_constant_sequencer") begin : g_bad_type
    $error("lpm_type must be lpm_constant_sequencer");
  end
  if (lpm_depth < 2 || lpm_depth > (1 << lpm_widthad)) begin : g_bad_depth
    $error("lpm_depth out of range for lpm_widthad");
  end
  if (lpm_width < 1) begin : g_bad_width
    $error("lpm_width must be at least 1");
  end

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   last_q, last_d;
  logic            loop_q, loop_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef LPM_CONSTSEQ_REPEAT_EN
  logic [PASS_W-1:0] pass_q, pass_d;
`endif

  logic                 idle;
  logic                 in_range;
  logic                 wr_ok;
  logic                 xfer;
  logic                 at_last;
  logic [lpm_width-1:0] rd_data;

  assign idle     = (state_q == ST_IDLE);
  assign in_range = ({1'b0, wraddress} < DEPTH_X);
  assign wr_ok    = wren & idle & in_range;

  lpm_constseq_regfile #(
    .W     (lpm_width),
    .DEPTH (lpm_depth),
    .AW    (AW),
    .CVAL  (lpm_cvalue)
  ) u_regfile (
    .clock   (clock),
    .aclr_n  (aclr_n),
    .we_i    (wr_ok),
    .waddr_i (wraddress),
    .wdata_i (data),
    .raddr_i (ptr_q),
    .rdata_o (rd_data)
  );

  assign st.result_valid = ~idle;
  assign st.result       = idle ? '0 : rd_data;
  assign busy            = ~idle;
  assign done            = done_q;
  assign wr_err          = err_q;

  assign xfer    = ~idle & st.result_ready;
  assign at_last = (ptr_q == last_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    err_d   = wren & ~(idle & in_range);
`ifdef LPM_CONSTSEQ_REPEAT_EN
    pass_d  = pass_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          ptr_d   = '0;
          loop_d  = loop;
          last_d  = (last_addr > LAST_MAX) ? LAST_MAX : last_addr;
`ifdef LPM_CONSTSEQ_REPEAT_EN
          pass_d  = repeat_count;
`endif
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (!at_last) begin
            ptr_d = ptr_q + AW'(1);
          end else if (loop_q) begin
            ptr_d = '0;
`ifdef LPM_CONSTSEQ_REPEAT_EN
          end else if (pass_q != '0) begin
            ptr_d  = '0;
            pass_d = pass_q - PASS_W'(1);
`endif
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        // An abort still lets a same-cycle transfer land, but never signals done.
        if (stop) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LPM_CONSTSEQ_REPEAT_EN
      pass_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LPM_CONSTSEQ_REPEAT_EN
      pass_q  <= pass_d;
`endif
    end
  end

endmodule

// File: tb/tb_lpm_constant_sequencer.sv
// Directed bench for lpm_constant_sequencer with a stream scoreboard.
// Covers LPM_CONSTSEQ_REPEAT_EN when that macro is defined.
module tb_lpm_constant_sequencer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 3;
  localparam logic [W-1:0] CV = 8'h5A;

  logic          clock = 1'b0;
  logic          aclr_n = 1'b0;
  logic          wren = 1'b0;
  logic [AW-1:0] wraddress = '0;
  logic [W-1:0]  data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          busy, done, wr_err;
`ifdef LPM_CONSTSEQ_REPEAT_EN
  logic [7:0]    rpt = '0;
`endif

  int vec = 0;
  int err = 0;
  int done_cnt = 0;
  int d0;
  logic [W-1:0] sb [$];

  lpm_constant_sequencer_if #(.lpm_width(W)) bus ();

  always #5 clock = ~clock;

  lpm_constant_sequencer #(
    .lpm_width   (W),
    .lpm_depth   (D),
    .lpm_widthad (AW),
    .lpm_cvalue  (CV)
  ) dut (
    .clock        (clock),
    .aclr_n       (aclr_n),
    .wren         (wren),
    .wraddress    (wraddress),
    .data         (data),
    .start        (start),
    .stop         (stop),
    .loop         (loop),
    .last_addr    (last_addr),
`ifdef LPM_CONSTSEQ_REPEAT_EN
    .repeat_count (rpt),
`endif
    .st           (bus),
    .busy         (busy),
    .done         (done),
    .wr_err       (wr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (aclr_n && bus.result_valid && bus.result_ready) begin
      if (sb.size() == 0) begin
        vec++;
        assert (sb.size() != 0) else begin
          err++;
          $error("FAIL xfer_unexpected obs=%0h exp=none", bus.result);
        end
      end else begin
        chk("xfer", bus.result, sb.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wren = 1'b1;
    wraddress = a;
    data = d;
    cyc();
    wren = 1'b0;
  endtask

  task automatic go(input logic l, input logic [AW-1:0] la);
    loop = l;
    last_addr = la;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      cyc();
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic finish_run(input string tag);
    d0 = done_cnt;
    wait_idle(40);
    chk({tag, "_done_hi"}, done, 1'b1);
    chk({tag, "_valid_lo"}, bus.result_valid, 1'b0);
    cyc();
    chk({tag, "_done_lo"}, done, 1'b0);
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    bus.result_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_result", bus.result, 8'h00);
    chk("rst_valid", bus.result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    aclr_n = 1'b1;
    cyc();

    // Reset constants played out in one pass.
    bus.result_ready = 1'b1;
    repeat (4) sb.push_back(CV);
    go(1'b0, 3'd3);
    chk("t1_busy", busy, 1'b1);
    finish_run("t1");

    // Table writes and back-pressure hold.
    bus.result_ready = 1'b0;
    wr(3'd0, 8'h11);
    wr(3'd1, 8'h22);
    wr(3'd2, 8'h33);
    wr(3'd3, 8'h44);
    chk("t2_wr_err", wr_err, 1'b0);
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    go(1'b0, 3'd2);
    repeat (3) begin
      chk("t2_hold_data", bus.result, 8'h11);
      chk("t2_hold_valid", bus.result_valid, 1'b1);
      cyc();
    end
    bus.result_ready = 1'b1;
    finish_run("t2");

    // Looped playback aborted by stop with ready low.
    repeat (3) begin
      sb.push_back(8'h11);
      sb.push_back(8'h22);
    end
    d0 = done_cnt;
    go(1'b1, 3'd1);
    repeat (6) cyc();
    bus.result_ready = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t3_busy", busy, 1'b0);
    chk("t3_valid", bus.result_valid, 1'b0);
    chk("t3_result", bus.result, 8'h00);
    chk("t3_done", done, 1'b0);
    cyc();
    chk("t3_done_cnt", done_cnt - d0, 0);
    chk("t3_sb_empty", sb.size(), 0);

    // Stop coinciding with a transfer: that transfer still counts.
    bus.result_ready = 1'b1;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    d0 = done_cnt;
    go(1'b1, 3'd1);
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t3b_busy", busy, 1'b0);
    cyc();
    chk("t3b_done_cnt", done_cnt - d0, 0);
    chk("t3b_sb_empty", sb.size(), 0);

    // start with stop while idle stays idle.
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk("t4_busy", busy, 1'b0);
    chk("t4_valid", bus.result_valid, 1'b0);

    // Rejected writes: while busy and out of range.
    bus.result_ready = 1'b0;
    go(1'b1, 3'd0);
    wr(3'd0, 8'hFF);
    chk("t5_err_busy", wr_err, 1'b1);
    cyc();
    chk("t5_err_clear", wr_err, 1'b0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    wr(3'd5, 8'h99);
    chk("t5_err_range", wr_err, 1'b1);
    cyc();
    chk("t5_err_clear2", wr_err, 1'b0);

    // last_addr beyond depth is clamped; entry 0 kept its value.
    bus.result_ready = 1'b1;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    sb.push_back(8'h44);
    go(1'b0, 3'd7);
    finish_run("t5_clamp");

    sb.push_back(8'h11);
    go(1'b0, 3'd0);
    finish_run("t5_single");

    // Asynchronous reset in the middle of a run.
    bus.result_ready = 1'b0;
    d0 = done_cnt;
    go(1'b0, 3'd3);
    chk("t6_valid_run", bus.result_valid, 1'b1);
    #2;
    aclr_n = 1'b0;
    #1;
    chk("t6_valid", bus.result_valid, 1'b0);
    chk("t6_result", bus.result, 8'h00);
    chk("t6_busy", busy, 1'b0);
    cyc();
    aclr_n = 1'b1;
    cyc();
    chk("t6_done_cnt", done_cnt - d0, 0);
    bus.result_ready = 1'b1;
    repeat (4) sb.push_back(CV);
    go(1'b0, 3'd3);
    finish_run("t6_cval");

`ifdef LPM_CONSTSEQ_REPEAT_EN
    wr(3'd0, 8'h11);
    wr(3'd1, 8'h22);
    repeat (3) begin
      sb.push_back(8'h11);
      sb.push_back(8'h22);
    end
    rpt = 8'd2;
    go(1'b0, 3'd1);
    rpt = 8'd0;
    finish_run("t7_repeat");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
